// File: rtl/mlp_sequencer.sv
// mlp_sequencer: time-multiplexed controller for the 8-input, 8-hidden, 1-output
// diabetes-risk MLP. A single shared multiply-accumulate walks a registered weight
// ROM (one cycle of read latency). Hidden activations are clamped to [0, 1.0], and
// the Q32.32 output is bucketed into a 2-bit risk class.
module mlp_sequencer #(
  parameter int N       = 8,
  parameter int NEURONS = 8,
  parameter int FRAC    = 16
) (
  input  logic            ADC_CLK_10,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [32*N-1:0] x_flat,
  output logic [6:0]      w_addr,
  input  logic [31:0]     w_data,
  output logic            ready,
  output logic            done,
  output logic [1:0]      result,
  output logic [31:0]     y_out
);

  // Counter must reach the bias cycle of the wider layer (terms + 1).
  localparam int MAX_TERMS = (N > NEURONS) ? N : NEURONS;
  localparam int CNT_W     = $clog2(MAX_TERMS + 2);
  localparam int NRN_W     = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  localparam logic [CNT_W-1:0] HID_LAST_C = CNT_W'(N + 1);
  localparam logic [CNT_W-1:0] OUT_LAST_C = CNT_W'(NEURONS + 1);
  localparam logic [CNT_W-1:0] N_C        = CNT_W'(N);
  localparam logic [CNT_W-1:0] NEURONS_C  = CNT_W'(NEURONS);
  localparam logic [NRN_W-1:0] NRN_LAST_C = NRN_W'(NEURONS - 1);
  localparam logic [6:0]       OUT_BASE   = 7'(NEURONS * (N + 1));

  // 1.0 in the Q32.32 accumulator and in the Q16.16 activation format.
  localparam logic signed [63:0] ONE_Q = 64'sd1 <<< (2 * FRAC);
  localparam logic [31:0]        ONE_H = 32'd1 << FRAC;

  // Class thresholds on the Q32.32 output (about 0.6, 0.5 and 0.4).
  localparam logic signed [63:0] TH3 = 64'sh0000_0000_9999_0000;
  localparam logic signed [63:0] TH2 = 64'sh0000_0000_8000_0000;
  localparam logic signed [63:0] TH1 = 64'sh0000_0000_6666_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HID   = 3'd1,
    S_ACT   = 3'd2,
    S_OUT   = 3'd3,
    S_CLASS = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NRN_W-1:0]   nrn_q, nrn_d;

  logic signed [63:0] acc_q, acc_d;
  logic signed [31:0] x_q [N];
  logic signed [31:0] h_q [NEURONS];

  logic [6:0]         w_addr_q, w_addr_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [1:0]         result_q;
  logic [31:0]        y_out_q;

  logic [CNT_W-1:0]   term_idx_s;
  logic signed [31:0] operand_s;
  logic signed [63:0] product_s;
  logic signed [63:0] bias_s;

  // ReLU clamp of a Q32.32 sum into [0, 1.0], returned as Q16.16.
  function automatic logic [31:0] clamp_act(input logic signed [63:0] a);
    logic [31:0] h;
    if (a < 64'sd0) begin
      h = 32'd0;
    end else if (a > ONE_Q) begin
      h = ONE_H;
    end else begin
      h = a[FRAC+31:FRAC];
    end
    return h;
  endfunction

  // Strict signed compare against the thresholds, highest class first.
  function automatic logic [1:0] classify(input logic signed [63:0] y);
    logic [1:0] c;
    if (y > TH3) begin
      c = 2'd3;
    end else if (y > TH2) begin
      c = 2'd2;
    end else if (y > TH1) begin
      c = 2'd1;
    end else begin
      c = 2'd0;
    end
    return c;
  endfunction

  // State register: FSM state, cycle-within-layer counter and neuron index.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      nrn_q   <= {NRN_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nrn_q   <= nrn_d;
    end
  end

  // Next-state logic: fixed walk IDLE -> (HID, ACT) x NEURONS -> OUT -> CLASS -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nrn_d   = nrn_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      nrn_d   = {NRN_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_HID;
            cnt_d   = {CNT_W{1'b0}};
            nrn_d   = {NRN_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HID: begin
          if (cnt_q == HID_LAST_C) begin
            state_d = S_ACT;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_ACT: begin
          cnt_d = {CNT_W{1'b0}};
          if (nrn_q == NRN_LAST_C) begin
            state_d = S_OUT;
            nrn_d   = {NRN_W{1'b0}};
          end else begin
            state_d = S_HID;
            nrn_d   = nrn_q + NRN_W'(1);
          end
        end
        S_OUT: begin
          if (cnt_q == OUT_LAST_C) begin
            state_d = S_CLASS;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CLASS: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          nrn_d   = {NRN_W{1'b0}};
        end
      endcase
    end
  end

  // Output logic: registered outputs are computed from the upcoming state so the
  // ROM address is presented in the same cycle the counter names it.
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    w_addr_d = 7'd0;
    if ((state_d == S_HID) && (cnt_d <= N_C)) begin
      w_addr_d = 7'(nrn_d) * 7'(N + 1) + 7'(cnt_d);
    end else if ((state_d == S_OUT) && (cnt_d <= NEURONS_C)) begin
      w_addr_d = OUT_BASE + 7'(cnt_d);
    end else begin
      w_addr_d = 7'd0;
    end
  end

  // Output registers.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_q <= 7'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      w_addr_q <= w_addr_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // ROM data returning in cycle c belongs to the address issued in cycle c-1.
  assign term_idx_s = cnt_q - CNT_W'(1);

  // MAC operand select: x during the hidden layer, h during the output layer.
  always_comb begin
    operand_s = 32'sd0;
    for (int k = 0; k < N; k++) begin
      operand_s = ((state_q == S_HID) && (term_idx_s == CNT_W'(k))) ? x_q[k] : operand_s;
    end
    for (int k = 0; k < NEURONS; k++) begin
      operand_s = ((state_q == S_OUT) && (term_idx_s == CNT_W'(k))) ? h_q[k] : operand_s;
    end
  end

  // Full 64-bit signed product (Q32.32) and the bias aligned to Q32.32.
  assign product_s = $signed({{32{operand_s[31]}}, operand_s}) * $signed({{32{w_data[31]}}, w_data});
  assign bias_s    = $signed({{(32-FRAC){w_data[31]}}, w_data, {FRAC{1'b0}}});

  // Accumulator next value: clear on cycle 0, products on term cycles, bias last.
  always_comb begin
    acc_d = acc_q;
    case (state_q)
      S_HID: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          acc_d = 64'sd0;
        end else if (cnt_q == HID_LAST_C) begin
          acc_d = acc_q + bias_s;
        end else begin
          acc_d = acc_q + product_s;
        end
      end
      S_OUT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          acc_d = 64'sd0;
        end else if (cnt_q == OUT_LAST_C) begin
          acc_d = acc_q + bias_s;
        end else begin
          acc_d = acc_q + product_s;
        end
      end
      default: acc_d = acc_q;
    endcase
  end

  // Datapath registers: accumulator, captured inputs, activations and the result.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 64'sd0;
      result_q <= 2'd0;
      y_out_q  <= 32'd0;
      for (int k = 0; k < N; k++) begin
        x_q[k] <= 32'sd0;
      end
      for (int k = 0; k < NEURONS; k++) begin
        h_q[k] <= 32'sd0;
      end
    end else begin
      acc_q <= acc_d;
      if ((state_q == S_IDLE) && start) begin
        for (int k = 0; k < N; k++) begin
          x_q[k] <= x_flat[32*k +: 32];
        end
      end
      if ((state_q == S_ACT) && !abort) begin
        h_q[nrn_q] <= clamp_act(acc_q);
      end
      if ((state_q == S_CLASS) && !abort) begin
        result_q <= classify(acc_q);
        y_out_q  <= acc_q[FRAC+31:FRAC];
      end
    end
  end

  assign w_addr = w_addr_q;
  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign y_out  = y_out_q;

endmodule
